jogo_sequencia_param: RTL

Parametrised sequence-memory game controller with progressive rounds and a per-move timeout. A control FSM and datapath compare switch moves against a stored sequence. Round r requires positions 0..r of the sequence; each completed round extends the sequence by one, until all N_JOGADAS positions have been matched. This is the top-level game core. Board-level 7-segment decoding sits outside this block and is driven from the raw db_* buses.

---
 rtl/jogo_pkg.sv | 24 ++
 rtl/memoria_sequencia.sv | 23 ++
 rtl/jogo_sequencia_param.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/jogo_pkg.sv
// Shared definitions for the sequence-memory game.
//   estado_t : FSM state type; the codes are visible on db_estado.
//   largura  : bit width needed to hold counter values 0..n-1 (minimum 1).
package jogo_pkg;

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        NOVA_RODADA    = 4'h2,
        ESPERA         = 4'h3,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMA        = 4'h6,
        PROXIMA_RODADA = 4'h7,
        FIM_ACERTO     = 4'hA,
        FIM_TIMEOUT    = 4'hD,
        FIM_ERRO       = 4'hE
    } estado_t;

    function automatic int unsigned largura(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/memoria_sequencia.sv
// Combinational sequence ROM, N_JOGADAS words of N_CHAVES bits.
// Word i holds a single set bit at position (i mod N_CHAVES): 1,2,4,8,1,...
//   endereco : word address (from the game address counter)
//   dado     : addressed word, follows endereco in the same cycle
module memoria_sequencia
    import jogo_pkg::*;
#(
    parameter int unsigned N_CHAVES  = 4,
    parameter int unsigned N_JOGADAS = 16
) (
    input  logic [largura(N_JOGADAS)-1:0] endereco,
    output logic [N_CHAVES-1:0]           dado
);

    logic [N_CHAVES-1:0] rom [N_JOGADAS];

    for (genvar i = 0; i < N_JOGADAS; i++) begin : g_rom
        assign rom[i] = N_CHAVES'(1) << (i % N_CHAVES);
    end

    assign dado = rom[endereco];

endmodule

// File: rtl/jogo_sequencia_param.sv
// Sequence-memory game core: control FSM plus datapath (address and round
// counters, move edge detector, move register, optional move timeout).
// Round r asks for sequence positions 0..r; the game is won after round
// N_JOGADAS-1 is completed.
//
// Optional feature macro: TIMEOUT_EN (per-move timeout of TIMEOUT_CICLOS
// cycles while waiting for a move; without it the wait is unbounded and
// timeout is tied low).
//
// Ports:
//   clock, reset   : rising-edge clock, asynchronous active-high reset
//   iniciar        : start/restart, honoured only in inicial and end states
//   chaves         : player move (one-hot expected)
//   acertou/errou/pronto/timeout : registered end-of-game flags
//   leds           : registered move
//   db_*           : debug taps (compare result, move edge, counters,
//                    addressed memory word, state code)
module jogo_sequencia_param
    import jogo_pkg::*;
#(
    parameter int unsigned N_CHAVES       = 4,
    parameter int unsigned N_JOGADAS      = 16,
    parameter int unsigned TIMEOUT_CICLOS = 5000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          iniciar,
    input  logic [N_CHAVES-1:0]           chaves,
    output logic                          acertou,
    output logic                          errou,
    output logic                          pronto,
    output logic                          timeout,
    output logic [N_CHAVES-1:0]           leds,
    output logic                          db_igual,
    output logic                          db_tem_jogada,
    output logic [largura(N_JOGADAS)-1:0] db_contagem,
    output logic [largura(N_JOGADAS)-1:0] db_rodada,
    output logic [N_CHAVES-1:0]           db_memoria,
    output logic [3:0]                    db_estado
);

    localparam int unsigned   CW     = largura(N_JOGADAS);
    localparam logic [CW-1:0] ULTIMA = CW'(N_JOGADAS - 1);

    estado_t             estado;
    logic [CW-1:0]       contagem;
    logic [CW-1:0]       rodada;
    logic [N_CHAVES-1:0] jogada;
    logic [N_CHAVES-1:0] chaves_ant;
    logic [N_CHAVES-1:0] memoria;
    logic                igual;
    logic                tem_jogada;
    logic                fim_tempo;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    memoria_sequencia #(
        .N_CHAVES  (N_CHAVES),
        .N_JOGADAS (N_JOGADAS)
    ) u_memoria (
        .endereco (contagem),
        .dado     (memoria)
    );

    // Move edge: switches active now, idle in the previous sample, so a
    // held switch yields one move only.
    assign tem_jogada = (chaves != '0) && (chaves_ant == '0);
    assign igual      = (jogada == memoria);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chaves_ant <= '0;
        end else begin
            chaves_ant <= chaves;
        end
    end

    // The move register loads the sample that produced the edge, so a
    // single-cycle press is still captured in registra.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contagem <= '0;
            rodada   <= '0;
            jogada   <= '0;
        end else begin
            case (estado)
                PREPARACAO: begin
                    contagem <= '0;
                    rodada   <= '0;
                    jogada   <= '0;
                end
                NOVA_RODADA: contagem <= '0;
                REGISTRA:    jogada   <= chaves_ant;
                PROXIMA: begin
                    if (contagem != ULTIMA) contagem <= contagem + 1'b1;
                end
                PROXIMA_RODADA: begin
                    if (rodada != ULTIMA) rodada <= rodada + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef TIMEOUT_EN
    localparam int unsigned TW = largura(TIMEOUT_CICLOS);

    logic [TW-1:0] conta_tempo;

    // Held at zero outside espera, so each wait starts from zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conta_tempo <= '0;
        end else if (estado != ESPERA) begin
            conta_tempo <= '0;
        end else begin
            conta_tempo <= conta_tempo + 1'b1;
        end
    end

    assign fim_tempo = (conta_tempo == TW'(TIMEOUT_CICLOS - 1));
`else
    logic unused_timeout_ciclos;

    assign unused_timeout_ciclos = (TIMEOUT_CICLOS == 0);
    assign fim_tempo             = 1'b0;
    assign timeout               = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Control FSM; end flags are decoded from the registered state and
    // therefore appear one cycle after the end state is entered.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado  <= INICIAL;
            acertou <= 1'b0;
            errou   <= 1'b0;
            pronto  <= 1'b0;
`ifdef TIMEOUT_EN
            timeout <= 1'b0;
`endif
        end else begin
            acertou <= (estado == FIM_ACERTO);
            errou   <= (estado == FIM_ERRO) || (estado == FIM_TIMEOUT);
            pronto  <= (estado == FIM_ACERTO) || (estado == FIM_ERRO) ||
                       (estado == FIM_TIMEOUT);
`ifdef TIMEOUT_EN
            timeout <= (estado == FIM_TIMEOUT);
`endif
            case (estado)
                INICIAL:        if (iniciar) estado <= PREPARACAO;
                PREPARACAO:     estado <= NOVA_RODADA;
                NOVA_RODADA:    estado <= ESPERA;
                ESPERA: begin
                    // A move arriving on the last allowed cycle wins.
                    if (tem_jogada)     estado <= REGISTRA;
                    else if (fim_tempo) estado <= FIM_TIMEOUT;
                end
                REGISTRA:       estado <= COMPARACAO;
                COMPARACAO: begin
                    if (!igual)                  estado <= FIM_ERRO;
                    else if (contagem < rodada)  estado <= PROXIMA;
                    else if (rodada == ULTIMA)   estado <= FIM_ACERTO;
                    else                         estado <= PROXIMA_RODADA;
                end
                PROXIMA:        estado <= ESPERA;
                PROXIMA_RODADA: estado <= NOVA_RODADA;
                FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                    if (iniciar) estado <= PREPARACAO;
                end
                default:        estado <= INICIAL;
            endcase
        end
    end

    assign leds          = jogada;
    assign db_igual      = igual;
    assign db_tem_jogada = tem_jogada;
    assign db_contagem   = contagem;
    assign db_rodada     = rodada;
    assign db_memoria    = memoria;
    assign db_estado     = estado;

endmodule
